adbg_jsp_wb_arbiter: RTL and testbench
======================================

ADBG_JSP_WB_ARBITER -- requirements
Module: adbg_jsp_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of Wishbone masters sharing one JSP BIU slave port (range 2-8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the stalled-strobe cycle limit before an error abort (range 2-1023).
REQ-003 The block SHALL have port wb_clk_i  in  1  sole clock; all logic is rising-edge.
REQ-004 The block SHALL have port wb_rst_i  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports m_cyc_i, m_stb_i, m_we_i  in  NUM_REQ each  per-master cycle, strobe and write-enable; bit i belongs to master i.
REQ-006 The block SHALL have ports m_adr_i  in  32*NUM_REQ, m_sel_i  in  4*NUM_REQ, m_dat_i  in  32*NUM_REQ  per-master address, byte select and write data; slice i belongs to master i.
REQ-007 The block SHALL have ports m_dat_o  out  32 (read data broadcast to all masters), m_ack_o  out  NUM_REQ, m_err_o  out  NUM_REQ.
REQ-008 The block SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1; s_adr_o  out  32; s_sel_o  out  4; s_dat_o  out  32  toward the BIU slave.
REQ-009 The block SHALL have ports s_dat_i  in  32, s_ack_i  in  1, s_err_i  in  1  from the BIU slave.
REQ-010 The block SHALL have ports grant_o  out  NUM_REQ (one-hot owner, all-zero when no owner) and timeout_o  out  1 (one-cycle abort pulse).

Function
REQ-011 The FSM SHALL have states IDLE, BUSY, ERR and RELEASE, with a registered grant vector and a registered last-owner pointer.
REQ-012 In IDLE, if any m_cyc_i bit is sampled high, the block SHALL load a one-hot grant and enter BUSY on the next edge; otherwise it SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: search starts at (last+1) mod NUM_REQ, ascending with wrap, and the first asserted m_cyc_i wins; last is updated to the winner.
REQ-014 In IDLE, ERR and RELEASE, all s_* outputs SHALL be zero; m_dat_o SHALL always equal s_dat_i.
REQ-015 In BUSY, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o and s_dat_o SHALL combinationally mirror the granted master's signals; non-granted masters SHALL never reach the slave.
REQ-016 In BUSY, m_ack_o[g] SHALL equal s_ack_i & s_stb_o and m_err_o[g] SHALL equal s_err_i & s_stb_o; all other ack/err bits SHALL be 0.
REQ-017 In BUSY, the grant SHALL be held while m_cyc_i[g] is high (burst/lock); m_cyc_i[g] sampled low SHALL return the FSM to IDLE, giving exactly one dead cycle between owners.
REQ-018 The stall counter, ceil(log2(TIMEOUT+1)) bits, SHALL clear on BUSY entry and on any cycle with s_ack_i or s_err_i, and SHALL increment on each BUSY cycle with s_stb_o high and no ack/err.
REQ-019 When the counter would reach TIMEOUT, the next state SHALL be ERR; if ack/err arrives in that same cycle, the ack/err SHALL win and no abort SHALL occur.
REQ-020 ERR SHALL last exactly one cycle, driving m_err_o[g]=1 and timeout_o=1, then SHALL enter RELEASE.
REQ-021 RELEASE SHALL hold the grant and wait for m_cyc_i[g] low, then SHALL return to IDLE; a master dropping cyc during ERR SHALL still pass through RELEASE for one cycle.
REQ-022 grant_o SHALL be nonzero exactly in BUSY, ERR and RELEASE.

Reset
REQ-023 Asserting wb_rst_i SHALL immediately force IDLE, grant=0, counter=0, last=NUM_REQ-1 (so master 0 has first priority), timeout_o=0, and all s_* and m_ack_o/m_err_o outputs 0, including mid-transfer.
REQ-024 After release of reset, arbitration SHALL begin on the first rising edge at which wb_rst_i is sampled low.

Verification
REQ-025 Masters 0 and 2 raise cyc together after reset -> grant_o=4'b0001 the next cycle; master 0 drops cyc -> one IDLE cycle -> grant_o=4'b0100.
REQ-026 All 4 masters request continuously, each doing 1 write then dropping cyc -> grant order 0,1,2,3,0 with exactly one grant_o=0 cycle between grants.
REQ-027 Master 1 writes s_dat_o=0x41000000 with sel=4'b1000, and the slave acks in cycle 2 -> m_ack_o=4'b0010 for one cycle, and other masters' adr/dat never appear on s_*.
REQ-028 TIMEOUT=4, master 3 strobes and the slave never acks -> 4 stall cycles, then m_err_o=4'b1000 and timeout_o=1 for 1 cycle, then s_stb_o=0 until cyc drops.
REQ-029 TIMEOUT=4, with ack on the 4th stall cycle -> m_ack_o pulses, timeout_o stays 0, and the FSM stays in BUSY.
REQ-030 wb_rst_i pulses during a BUSY burst of master 2 -> outputs zero asynchronously; after release, master 0 is served before master 2 when both request.

Source files
------------

// File: rtl/adbg_jsp_wb_arbiter.sv
// ============================================================================
// adbg_jsp_wb_arbiter
//
// Round-robin Wishbone arbiter. It lets NUM_REQ masters share the single JSP
// BIU slave port. One master owns the slave at a time. The owner keeps the
// grant for as long as it holds m_cyc_i, so locked bursts are never split.
// If a strobe stalls for TIMEOUT cycles with no ack or err from the slave,
// the transfer is aborted. The owner then sees a one-cycle error, and
// timeout_o pulses for that same cycle.
//
// Parameters
//   NUM_REQ  number of masters (2..8)
//   TIMEOUT  number of stalled strobe cycles before an abort (2..1023)
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   m_cyc_i/stb_i/we_i      per-master cycle, strobe, write enable (bit i)
//   m_adr_i/sel_i/dat_i     per-master address, byte select, write data
//                           (slice i belongs to master i)
//   m_dat_o                 read data, broadcast to every master
//   m_ack_o, m_err_o        per-master ack / error
//   s_*_o                   request toward the BIU slave
//   s_dat_i/ack_i/err_i     response from the BIU slave
//   grant_o                 one-hot current owner, zero when there is no owner
//   timeout_o               one-cycle pulse on a stall abort
// ============================================================================
module adbg_jsp_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_REQ-1:0]     m_cyc_i,
    input  logic [NUM_REQ-1:0]     m_stb_i,
    input  logic [NUM_REQ-1:0]     m_we_i,
    input  logic [32*NUM_REQ-1:0]  m_adr_i,
    input  logic [4*NUM_REQ-1:0]   m_sel_i,
    input  logic [32*NUM_REQ-1:0]  m_dat_i,
    output logic [31:0]            m_dat_o,
    output logic [NUM_REQ-1:0]     m_ack_o,
    output logic [NUM_REQ-1:0]     m_err_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [31:0]            s_adr_o,
    output logic [3:0]             s_sel_o,
    output logic [31:0]            s_dat_o,
    input  logic [31:0]            s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   timeout_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ERR     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] grant_next;
    logic [IW-1:0]      last;
    logic [IW-1:0]      last_next;
    logic [CW-1:0]      stall_cnt;
    logic [CW-1:0]      stall_cnt_next;

    logic               req_found;
    logic [IW-1:0]      req_winner;

    logic [31:0]        adr_arr [NUM_REQ];
    logic [31:0]        dat_arr [NUM_REQ];
    logic [3:0]         sel_arr [NUM_REQ];

    logic               own_cyc;
    logic               own_stb;
    logic               own_we;
    logic               stall_hit;

    // Split the flat per-master buses into arrays. The owner's fields can
    // then be selected by index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign adr_arr[i] = m_adr_i[32*i +: 32];
        assign dat_arr[i] = m_dat_i[32*i +: 32];
        assign sel_arr[i] = m_sel_i[4*i +: 4];
    end

    // "last" is loaded with the winner, so outside IDLE it is the owner index.
    assign own_cyc = m_cyc_i[last];
    assign own_stb = m_stb_i[last];
    assign own_we  = m_we_i[last];

    // A stalled strobe at this count would bring the counter to TIMEOUT.
    assign stall_hit = (stall_cnt == CW'(TIMEOUT - 1));

    assign grant_o = grant;
    assign m_dat_o = s_dat_i;

    // Round-robin search. It starts just after the previous owner and wraps.
    // The first master that holds cyc wins.
    always_comb begin : rr_search
        logic [IW-1:0] idx;
        idx        = '0;
        req_found  = 1'b0;
        req_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (!req_found && m_cyc_i[idx]) begin
                req_found  = 1'b1;
                req_winner = idx;
            end
        end
    end

    // Next-state logic and outputs. The slave only sees the owner's signals,
    // and only in BUSY. The stall counter restarts whenever the slave
    // responds, so an ack in the final allowed cycle prevents the abort.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        last_next      = last;
        stall_cnt_next = '0;
        s_cyc_o        = 1'b0;
        s_stb_o        = 1'b0;
        s_we_o         = 1'b0;
        s_adr_o        = '0;
        s_sel_o        = '0;
        s_dat_o        = '0;
        m_ack_o        = '0;
        m_err_o        = '0;
        timeout_o      = 1'b0;

        case (state)
            IDLE: begin
                if (req_found) begin
                    state_next             = BUSY;
                    grant_next             = '0;
                    grant_next[req_winner] = 1'b1;
                    last_next              = req_winner;
                end
            end
            BUSY: begin
                s_cyc_o       = own_cyc;
                s_stb_o       = own_stb;
                s_we_o        = own_we;
                s_adr_o       = adr_arr[last];
                s_sel_o       = sel_arr[last];
                s_dat_o       = dat_arr[last];
                m_ack_o[last] = s_ack_i & own_stb;
                m_err_o[last] = s_err_i & own_stb;
                if (!own_cyc) begin
                    state_next = IDLE;
                    grant_next = '0;
                end else if (s_ack_i || s_err_i) begin
                    stall_cnt_next = '0;
                end else if (own_stb) begin
                    if (stall_hit) begin
                        state_next = ERR;
                    end else begin
                        stall_cnt_next = stall_cnt + 1'b1;
                    end
                end else begin
                    stall_cnt_next = stall_cnt;
                end
            end
            ERR: begin
                m_err_o[last] = 1'b1;
                timeout_o     = 1'b1;
                state_next    = RELEASE;
            end
            RELEASE: begin
                // Keep the grant until the aborted master lets go of cyc.
                // This stops it from finishing a transfer on the slave.
                if (!own_cyc) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State registers. Reset sets last to the top index, so master 0 has
    // first priority afterwards.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= IW'(NUM_REQ - 1);
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            last      <= last_next;
            stall_cnt <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_adbg_jsp_wb_arbiter.sv
// ============================================================================
// tb_adbg_jsp_wb_arbiter
//
// Bench for adbg_jsp_wb_arbiter with NUM_REQ=4 and TIMEOUT=4. Directed
// scenarios come first, followed by a randomized run. A transaction-level
// model (owner, stall count, abort/release flags) predicts every output in
// every cycle.
// ============================================================================
module tb_adbg_jsp_wb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 4;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    m_cyc;
    logic [NUM_REQ-1:0]    m_stb;
    logic [NUM_REQ-1:0]    m_we;
    logic [32*NUM_REQ-1:0] m_adr;
    logic [4*NUM_REQ-1:0]  m_sel;
    logic [32*NUM_REQ-1:0] m_dat;
    logic [31:0]           m_dat_o;
    logic [NUM_REQ-1:0]    m_ack_o;
    logic [NUM_REQ-1:0]    m_err_o;
    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic                  s_we_o;
    logic [31:0]           s_adr_o;
    logic [3:0]            s_sel_o;
    logic [31:0]           s_dat_o;
    logic [31:0]           s_dat;
    logic                  s_ack;
    logic                  s_err;
    logic [NUM_REQ-1:0]    grant_o;
    logic                  timeout_o;

    int checks;
    int errors;

    // Reference model state
    int                 mdl_owner;
    int                 mdl_last;
    int                 mdl_stall;
    bit                 mdl_abort;
    bit                 mdl_release;
    logic [NUM_REQ-1:0] exp_ack_last;

    adbg_jsp_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_adr_i   (m_adr),
        .m_sel_i   (m_sel),
        .m_dat_i   (m_dat),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_sel_o   (s_sel_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] cyc, input logic [NUM_REQ-1:0] stb,
                                 input logic [NUM_REQ-1:0] we, input logic ack, input logic err);
        m_cyc = cyc;
        m_stb = stb;
        m_we  = we;
        s_ack = ack;
        s_err = err;
    endtask

    task automatic setMaster(input int i, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat);
        m_adr[i*32 +: 32] = adr;
        m_sel[i*4 +: 4]   = sel;
        m_dat[i*32 +: 32] = dat;
    endtask

    task automatic modelReset();
        mdl_owner   = -1;
        mdl_last    = NUM_REQ - 1;
        mdl_stall   = 0;
        mdl_abort   = 1'b0;
        mdl_release = 1'b0;
    endtask

    // Advance the model over one rising edge, using the inputs held in the
    // cycle that just ended.
    task automatic modelStep();
        int c;
        if (rst) begin
            modelReset();
            return;
        end
        if (mdl_owner < 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (mdl_last + k) % NUM_REQ;
                if (mdl_owner < 0 && m_cyc[c]) mdl_owner = c;
            end
            if (mdl_owner >= 0) begin
                mdl_last  = mdl_owner;
                mdl_stall = 0;
            end
        end else if (mdl_abort) begin
            mdl_abort   = 1'b0;
            mdl_release = 1'b1;
        end else if (mdl_release) begin
            if (!m_cyc[mdl_owner]) begin
                mdl_owner   = -1;
                mdl_release = 1'b0;
            end
        end else begin
            if (!m_cyc[mdl_owner]) begin
                mdl_owner = -1;
            end else if (s_ack || s_err) begin
                mdl_stall = 0;
            end else if (m_stb[mdl_owner]) begin
                mdl_stall = mdl_stall + 1;
                if (mdl_stall == TIMEOUT) begin
                    mdl_abort = 1'b1;
                    mdl_stall = 0;
                end
            end
        end
    endtask

    // Predict every output from the model and the current inputs.
    task automatic compareAll();
        bit                 active;
        int                 o;
        logic [NUM_REQ-1:0] one;
        logic [NUM_REQ-1:0] e_ack;
        logic [NUM_REQ-1:0] e_err;
        o      = (mdl_owner < 0) ? 0 : mdl_owner;
        one    = 4'b0001 << o;
        active = (mdl_owner >= 0) && !mdl_abort && !mdl_release;
        e_ack  = (active && s_ack && m_stb[o]) ? one : '0;
        e_err  = ((active && s_err && m_stb[o]) || mdl_abort) ? one : '0;
        exp_ack_last = e_ack;
        checkOutput("grant_o",   64'(grant_o),   (mdl_owner >= 0) ? 64'(one) : 64'h0);
        checkOutput("s_cyc_o",   64'(s_cyc_o),   active ? 64'(m_cyc[o]) : 64'h0);
        checkOutput("s_stb_o",   64'(s_stb_o),   active ? 64'(m_stb[o]) : 64'h0);
        checkOutput("s_we_o",    64'(s_we_o),    active ? 64'(m_we[o]) : 64'h0);
        checkOutput("s_adr_o",   64'(s_adr_o),   active ? 64'(m_adr[o*32 +: 32]) : 64'h0);
        checkOutput("s_sel_o",   64'(s_sel_o),   active ? 64'(m_sel[o*4 +: 4]) : 64'h0);
        checkOutput("s_dat_o",   64'(s_dat_o),   active ? 64'(m_dat[o*32 +: 32]) : 64'h0);
        checkOutput("m_ack_o",   64'(m_ack_o),   64'(e_ack));
        checkOutput("m_err_o",   64'(m_err_o),   64'(e_err));
        checkOutput("timeout_o", 64'(timeout_o), 64'(mdl_abort));
        checkOutput("m_dat_o",   64'(m_dat_o),   64'(s_dat));
    endtask

    // One clock cycle: compare on the falling edge, then step the model on
    // the rising edge. Control returns 1 time unit after that edge.
    task automatic tick();
        if (rst) modelReset();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    logic [NUM_REQ-1:0] drop;
    logic [NUM_REQ-1:0] rr_expected [13];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        m_adr  = '0;
        m_sel  = '0;
        m_dat  = '0;
        s_dat  = '0;
        drop   = '0;
        exp_ack_last = '0;
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        modelReset();
        rr_expected = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                        4'h8, 4'h8, 4'h0, 4'h1};
        #1;
        repeat (3) tick();
        checkOutput("reset_grant",   64'(grant_o),   64'h0);
        checkOutput("reset_timeout", 64'(timeout_o), 64'h0);
        checkOutput("reset_s_cyc",   64'(s_cyc_o),   64'h0);
        rst = 1'b0;

        $display("[TB] masters 0 and 2 request together");
        applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("rr_first_grant", 64'(grant_o), 64'h1);
        tick();
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("dead_cycle_grant", 64'(grant_o), 64'h0);
        tick();
        checkOutput("rr_second_grant", 64'(grant_o), 64'h4);
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        repeat (2) tick();

        $display("[TB] master 1 write with ack in cycle 2");
        setMaster(0, 32'hDEAD_0000, 4'hF, 32'hBAD0_0000);
        setMaster(1, 32'h0000_1000, 4'b1000, 32'h4100_0000);
        setMaster(2, 32'hDEAD_0002, 4'hF, 32'hBAD0_0002);
        setMaster(3, 32'hDEAD_0003, 4'hF, 32'hBAD0_0003);
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0);
        tick();
        checkOutput("wr_grant", 64'(grant_o), 64'h2);
        checkOutput("wr_s_dat", 64'(s_dat_o), 64'h4100_0000);
        checkOutput("wr_s_sel", 64'(s_sel_o), 64'h8);
        checkOutput("wr_s_adr", 64'(s_adr_o), 64'h1000);
        checkOutput("wr_no_ack_yet", 64'(m_ack_o), 64'h0);
        tick();
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0);
        #1;
        checkOutput("wr_ack", 64'(m_ack_o), 64'h2);
        tick();
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("wr_ack_gone", 64'(m_ack_o), 64'h0);
        repeat (2) tick();

        $display("[TB] master 3 stalls until timeout");
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            checkOutput("stall_stb", 64'(s_stb_o), 64'h1);
            checkOutput("stall_no_timeout", 64'(timeout_o), 64'h0);
            tick();
        end
        checkOutput("abort_err", 64'(m_err_o), 64'h8);
        checkOutput("abort_timeout", 64'(timeout_o), 64'h1);
        checkOutput("abort_stb", 64'(s_stb_o), 64'h0);
        tick();
        repeat (2) begin
            checkOutput("release_stb", 64'(s_stb_o), 64'h0);
            checkOutput("release_timeout", 64'(timeout_o), 64'h0);
            checkOutput("release_grant", 64'(grant_o), 64'h8);
            tick();
        end
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("release_done_grant", 64'(grant_o), 64'h0);
        tick();

        $display("[TB] ack on the last stall cycle");
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);
        tick();
        repeat (TIMEOUT - 1) tick();
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0);
        #1;
        checkOutput("late_ack", 64'(m_ack_o), 64'h8);
        checkOutput("late_ack_timeout", 64'(timeout_o), 64'h0);
        tick();
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("late_ack_grant", 64'(grant_o), 64'h8);
        checkOutput("late_ack_stb", 64'(s_stb_o), 64'h1);
        checkOutput("late_ack_err", 64'(m_err_o), 64'h0);
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        repeat (2) tick();

        $display("[TB] four masters single writes round-robin");
        for (int n = 0; n < 13; n++) begin
            applyStimulus(4'b1111 & ~drop, 4'b1111 & ~drop, 4'b1111, 1'b1, 1'b0);
            tick();
            checkOutput("rr_order", 64'(grant_o), 64'(rr_expected[n]));
            drop = exp_ack_last;
        end
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        repeat (2) tick();

        $display("[TB] reset during master 2 burst");
        setMaster(2, 32'h0000_2222, 4'hF, 32'h2222_2222);
        applyStimulus(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0);
        tick();
        checkOutput("burst_grant", 64'(grant_o), 64'h4);
        repeat (2) tick();
        applyStimulus(4'b0101, 4'b0101, 4'b0100, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_grant", 64'(grant_o), 64'h0);
        checkOutput("async_rst_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("async_rst_stb", 64'(s_stb_o), 64'h0);
        checkOutput("async_rst_adr", 64'(s_adr_o), 64'h0);
        checkOutput("async_rst_ack", 64'(m_ack_o), 64'h0);
        checkOutput("async_rst_err", 64'(m_err_o), 64'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_priority", 64'(grant_o), 64'h1);
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        repeat (2) tick();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 7) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
                m_we[i]  = 1'($urandom_range(0, 1));
                setMaster(i, $urandom(), 4'($urandom()), $urandom());
            end
            s_ack = ($urandom_range(0, 3) == 0);
            s_err = ($urandom_range(0, 15) == 0);
            s_dat = $urandom();
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
